// File: rtl/placement_readout_if.sv
// Record stream from the placement readout to the result dump/evaluation logic.
// Producer holds rec_valid and the payload stable until rec_ready is seen.
interface placement_readout_if #(
  parameter int POS_AW = 7,
  parameter int DATA_W = 32
);
  logic              rec_valid;
  logic              rec_ready;
  logic [POS_AW-1:0] rec_node;
  logic [DATA_W-1:0] rec_x;
  logic [DATA_W-1:0] rec_y;
  logic [2:0]        rec_flags;

  modport master (
    output rec_valid, rec_node, rec_x, rec_y, rec_flags,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_node, rec_x, rec_y, rec_flags,
    output rec_ready
  );
endinterface

// File: rtl/placement_readout.sv
// Walks every node, reads (x,y) from pos_X/pos_Y, cross-checks grid[x*GRID_N+y], emits one record per node.
// 6 cycles per placed node, 4 per unplaced/out-of-range node; EMIT stalls while rec_ready is low.
module placement_readout #(
  parameter int N_NODES = 64,
  parameter int GRID_N  = 6,
  parameter int POS_AW  = 7,
  parameter int GRID_AW = 6,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pos_re,
  output logic [POS_AW-1:0]  pos_addr,
  input  logic [DATA_W-1:0]  posx_rdata,
  input  logic [DATA_W-1:0]  posy_rdata,
  output logic               grid_re,
  output logic [GRID_AW-1:0] grid_addr,
  input  logic [DATA_W-1:0]  grid_rdata,
  placement_readout_if.master rec,
  output logic [15:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_POS, S_WAIT_POS, S_CHECK, S_RD_GRID, S_WAIT_GRID, S_EMIT, S_DONE
  } state_t;

  localparam logic signed [DATA_W-1:0] GRID_LIM  = DATA_W'(GRID_N);
  localparam logic [POS_AW-1:0]        LAST_NODE = POS_AW'(N_NODES - 1);

  state_t                     state_q, state_d;
  logic [POS_AW-1:0]          node_q;
  logic signed [DATA_W-1:0]   x_q, y_q;
  logic [2:0]                 flags_q;
  logic [GRID_AW-1:0]         gaddr_q;
  logic [15:0]                err_q;
  logic                       unplaced, out_of_range, grid_mismatch;

  assign unplaced      = (x_q == -1) || (y_q == -1);
  assign out_of_range  = (x_q < 0) || (y_q < 0) || (x_q >= GRID_LIM) || (y_q >= GRID_LIM);
  assign grid_mismatch = (grid_rdata != DATA_W'(node_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_RD_POS;
      S_RD_POS:    state_d = S_WAIT_POS;
      S_WAIT_POS:  state_d = S_CHECK;
      S_CHECK:     state_d = (unplaced || out_of_range) ? S_EMIT : S_RD_GRID;
      S_RD_GRID:   state_d = S_WAIT_GRID;
      S_WAIT_GRID: state_d = S_EMIT;
      S_EMIT:      if (rec.rec_ready) state_d = (node_q == LAST_NODE) ? S_DONE : S_RD_POS;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      node_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
      gaddr_q <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          node_q <= '0;
          err_q  <= '0;
        end
        S_WAIT_POS: begin
          x_q <= posx_rdata;
          y_q <= posy_rdata;
        end
        S_CHECK: begin
          if (unplaced)          flags_q <= 3'b001;
          else if (out_of_range) flags_q <= 3'b010;
          else begin
            // product formed at full data width, then truncated to the grid address
            flags_q <= 3'b000;
            gaddr_q <= GRID_AW'(x_q * GRID_LIM + y_q);
          end
        end
        S_WAIT_GRID: flags_q <= {grid_mismatch, 2'b00};
        S_EMIT: if (rec.rec_ready) begin
          if ((flags_q != 3'b000) && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
          if (node_q != LAST_NODE) node_q <= node_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign pos_re        = (state_q == S_RD_POS);
  assign grid_re       = (state_q == S_RD_GRID);
  assign pos_addr      = node_q;
  assign grid_addr     = gaddr_q;
  assign err_count     = err_q;
  assign rec.rec_valid = (state_q == S_EMIT);
  assign rec.rec_node  = node_q;
  assign rec.rec_x     = x_q;
  assign rec.rec_y     = y_q;
  assign rec.rec_flags = flags_q;

endmodule

// File: tb/tb_placement_readout.sv
// Bench for placement_readout: table-driven scans, stall/reset sequences, randomized scans vs a node-level model.
module tb_placement_readout;
  localparam int NN  = 4;
  localparam int GN  = 6;
  localparam int PAW = 7;
  localparam int GAW = 6;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, pos_re, grid_re;
  logic [PAW-1:0] pos_addr;
  logic [GAW-1:0] grid_addr;
  logic [DW-1:0]  posx_rdata = '0, posy_rdata = '0, grid_rdata = '0;
  logic [15:0]    err_count;

  placement_readout_if #(.POS_AW(PAW), .DATA_W(DW)) rif ();

  placement_readout #(.N_NODES(NN), .GRID_N(GN), .POS_AW(PAW), .GRID_AW(GAW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pos_re(pos_re), .pos_addr(pos_addr), .posx_rdata(posx_rdata), .posy_rdata(posy_rdata),
    .grid_re(grid_re), .grid_addr(grid_addr), .grid_rdata(grid_rdata),
    .rec(rif.master), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int posx_mem [128];
  int posy_mem [128];
  int grid_mem [64];

  always @(posedge clk) begin
    if (pos_re) begin
      posx_rdata <= posx_mem[pos_addr];
      posy_rdata <= posy_mem[pos_addr];
    end
    if (grid_re) grid_rdata <= grid_mem[grid_addr];
  end

  typedef struct { int x; int y; int gval; int flags; int gaddr; } vec_t;
  typedef struct { int node; int x; int y; int flags; } rec_t;

  vec_t tbl [12];
  rec_t got [$];
  int   got_ga [$];
  int   exp_ga [$];
  int   exp_flags [NN];
  int   exp_x [NN];
  int   exp_y [NN];
  int   exp_err, exp_cyc, cyc;
  bit   done_seen;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pos_re"}, pos_re, 0);
    chk({tag, "_grid_re"}, grid_re, 0);
    chk({tag, "_rec_valid"}, rif.rec_valid, 0);
    chk({tag, "_pos_addr"}, pos_addr, 0);
    chk({tag, "_grid_addr"}, grid_addr, 0);
    chk({tag, "_rec_node"}, rif.rec_node, 0);
    chk({tag, "_rec_x"}, rif.rec_x, 0);
    chk({tag, "_rec_y"}, rif.rec_y, 0);
    chk({tag, "_rec_flags"}, rif.rec_flags, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic load_table_scan(input int s);
    vec_t v;
    for (int a = 0; a < 64; a++) grid_mem[a] = -1;
    exp_ga.delete();
    exp_err = 0;
    exp_cyc = 0;
    for (int n = 0; n < NN; n++) begin
      v = tbl[s*NN + n];
      posx_mem[n] = v.x;
      posy_mem[n] = v.y;
      exp_x[n] = v.x;
      exp_y[n] = v.y;
      exp_flags[n] = v.flags;
      if (v.gaddr >= 0) begin
        grid_mem[v.gaddr] = v.gval;
        exp_ga.push_back(v.gaddr);
        exp_cyc += 6;
      end else exp_cyc += 4;
      if (v.flags != 0) exp_err++;
    end
  endtask

  // Node-level reference: classify each node from memory contents directly.
  task automatic model_scan();
    int x, y, a, f;
    exp_ga.delete();
    exp_err = 0;
    exp_cyc = 0;
    for (int n = 0; n < NN; n++) begin
      x = posx_mem[n];
      y = posy_mem[n];
      if (x == -1 || y == -1) begin
        f = 1; exp_cyc += 4;
      end else if (x < 0 || y < 0 || x >= GN || y >= GN) begin
        f = 2; exp_cyc += 4;
      end else begin
        a = x * GN + y;
        exp_ga.push_back(a);
        f = (grid_mem[a] != n) ? 4 : 0;
        exp_cyc += 6;
      end
      exp_x[n] = x;
      exp_y[n] = y;
      exp_flags[n] = f;
      if (f != 0) exp_err++;
    end
  endtask

  task automatic random_fill();
    int k, x, y;
    for (int a = 0; a < 64; a++) grid_mem[a] = int'($urandom_range(0, 8)) - 1;
    for (int n = 0; n < NN; n++) begin
      k = int'($urandom_range(0, 9));
      x = int'($urandom_range(0, GN-1));
      y = int'($urandom_range(0, GN-1));
      if (k == 0) x = -1;
      else if (k == 1) y = -1;
      else if (k == 2) x = int'($urandom_range(GN, 40));
      else if (k == 3) y = -int'($urandom_range(2, 9));
      else if (k == 4) x = -2147483647 - 1;
      else if ($urandom_range(0, 3) != 0) grid_mem[x*GN + y] = n;
      posx_mem[n] = x;
      posy_mem[n] = y;
    end
  endtask

  task automatic run_scan(input bit rnd);
    rec_t held, cur;
    bit   held_vld = 0;
    got.delete();
    got_ga.delete();
    cyc = 0;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    rif.rec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int t = 0; t < 2000 && !done_seen; t++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (grid_re) got_ga.push_back(int'(grid_addr));
      cur.node  = int'(rif.rec_node);
      cur.x     = int'($signed(rif.rec_x));
      cur.y     = int'($signed(rif.rec_y));
      cur.flags = int'(rif.rec_flags);
      if (held_vld) begin
        chk("stall_valid", rif.rec_valid, 1);
        chk("stall_node", cur.node, held.node);
        chk("stall_x", cur.x, held.x);
        chk("stall_flags", cur.flags, held.flags);
      end
      held_vld = rif.rec_valid && !rif.rec_ready;
      held = cur;
      if (rif.rec_valid && rif.rec_ready) got.push_back(cur);
      if (done) done_seen = 1;
      else begin
        @(posedge clk); #1;
        start = rnd && busy && ($urandom_range(0, 3) == 0);
        rif.rec_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
    chk("done_seen", done_seen, 1);
  endtask

  task automatic check_scan(input string tag);
    chk({tag, "_rec_count"}, got.size(), NN);
    for (int i = 0; i < got.size() && i < NN; i++) begin
      chk({tag, "_node"}, got[i].node, i);
      chk({tag, "_x"}, got[i].x, exp_x[i]);
      chk({tag, "_y"}, got[i].y, exp_y[i]);
      chk({tag, "_flags"}, got[i].flags, exp_flags[i]);
    end
    chk({tag, "_grid_reads"}, got_ga.size(), exp_ga.size());
    for (int i = 0; i < got_ga.size() && i < exp_ga.size(); i++)
      chk({tag, "_grid_addr"}, got_ga[i], exp_ga[i]);
    chk({tag, "_err_count"}, err_count, exp_err);
    if (exp_cyc >= 0) chk({tag, "_busy_cycles"}, cyc, exp_cyc);
    @(posedge clk); #1;
    start = 1'b0;
    rif.rec_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    tbl[0]  = '{0, 0, 0, 0, 0};    tbl[1]  = '{0, 1, 1, 0, 1};
    tbl[2]  = '{5, 5, 2, 0, 35};   tbl[3]  = '{2, 3, 3, 0, 15};
    tbl[4]  = '{0, 0, 0, 0, 0};    tbl[5]  = '{-1, -1, 0, 1, -1};
    tbl[6]  = '{6, 0, 0, 2, -1};   tbl[7]  = '{2, 3, 7, 4, 15};
    tbl[8]  = '{-1, 4, 0, 1, -1};  tbl[9]  = '{3, -2, 0, 2, -1};
    tbl[10] = '{4, 4, 9, 4, 28};   tbl[11] = '{0, 6, 0, 2, -1};
    for (int a = 0; a < 128; a++) begin posx_mem[a] = -1; posy_mem[a] = -1; end
    rif.rec_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int s = 0; s < 3; s++) begin
      load_table_scan(s);
      run_scan(0);
      check_scan($sformatf("table%0d", s));
    end

    // Stall node 0 for five cycles, pulse start while busy, then release.
    load_table_scan(0);
    @(posedge clk); #1;
    start = 1'b1;
    rif.rec_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = rif.rec_valid;
    end
    chk("stall_reach_emit", ok, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 2);
      @(negedge clk);
      chk("stall5_valid", rif.rec_valid, 1);
      chk("stall5_node", rif.rec_node, 0);
      chk("stall5_x", rif.rec_x, 0);
      chk("stall5_pos_re", pos_re, 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rif.rec_ready = 1'b1;
    @(negedge clk);
    chk("stall5_handshake_valid", rif.rec_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall5_next_pos_re", pos_re, 1);
    chk("stall5_next_pos_addr", pos_addr, 1);
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = done;
    end
    chk("stall5_done", ok, 1);
    @(negedge clk);
    chk("stall5_err_count", err_count, 0);

    // Reset asserted in WAIT_GRID of node 2 aborts the scan.
    load_table_scan(0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = grid_re && (rif.rec_node == 2);
    end
    chk("rst_reach_node2_grid", ok, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    reset = 1'b1;
    run_scan(0);
    check_scan("after_reset");

    for (int r = 0; r < 16; r++) begin
      random_fill();
      model_scan();
      run_scan(r % 2 == 1);
      if (r % 2 == 1) exp_cyc = -1;
      check_scan($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
